func_job_scheduler: RTL

//  Shares one func_fsm solver among N_REQ requesters. Grants jobs round-robin,

---
 rtl/func_job_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/func_job_scheduler.sv
// Round-robin job scheduler that shares one func_fsm engine among N_REQ requesters:
// grants a job, streams its operand nibbles to the engine, starts it, and returns the result or a timeout.
module func_job_scheduler #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [16*N_REQ-1:0]       op_data,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic signed [14:0]        rsp_data,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic                      eng_clr,
    output logic [3:0]                eng_in,
    output logic                      eng_s1,
    output logic                      eng_s2,
    output logic                      eng_s3,
    output logic                      eng_s4,
    output logic                      eng_ready,
    input  logic signed [14:0]        eng_out,
    input  logic                      eng_valid
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_LD_X, S_LD_DX, S_LD_U, S_LD_A, S_START, S_WAIT, S_RESP
    } state_t;

    state_t             r_state;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_owner;
    logic [15:0]        r_ops;
    logic [CW-1:0]      r_cnt;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic signed [14:0] r_rsp_data;
    logic               r_rsp_timeout;
    logic               r_eng_clr;
    logic [3:0]         r_eng_in;
    logic [3:0]         r_strb;
    logic               r_eng_ready;

    logic [IW-1:0]      w_cand;
    logic [IW-1:0]      w_win_idx;
    logic               w_win_any;

    // Scan starts just past the last served requester so it drops to lowest priority.
    always_comb begin
        w_win_any = 1'b0;
        w_win_idx = '0;
        w_cand    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_cand = IW'((32'(r_ptr) + k) % N_REQ);
            if (!w_win_any && req[w_cand]) begin
                w_win_any = 1'b1;
                w_win_idx = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= IW'(N_REQ - 1);
            r_owner       <= '0;
            r_ops         <= '0;
            r_cnt         <= '0;
            r_grant       <= '0;
            r_rsp_valid   <= '0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
            r_eng_clr     <= 1'b0;
            r_eng_in      <= '0;
            r_strb        <= '0;
            r_eng_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_any) begin
                        r_owner   <= w_win_idx;
                        r_ops     <= op_data[32'(w_win_idx)*16 +: 16];
                        r_grant   <= N_REQ'(1) << w_win_idx;
                        r_eng_clr <= 1'b1;
                        r_state   <= S_CLR;
                    end
                end
                S_CLR: begin
                    r_grant   <= '0;
                    r_eng_clr <= 1'b0;
                    r_eng_in  <= r_ops[3:0];
                    r_strb    <= 4'b0001;
                    r_state   <= S_LD_X;
                end
                S_LD_X: begin
                    r_eng_in <= r_ops[7:4];
                    r_strb   <= 4'b0010;
                    r_state  <= S_LD_DX;
                end
                S_LD_DX: begin
                    r_eng_in <= r_ops[11:8];
                    r_strb   <= 4'b0100;
                    r_state  <= S_LD_U;
                end
                S_LD_U: begin
                    r_eng_in <= r_ops[15:12];
                    r_strb   <= 4'b1000;
                    r_state  <= S_LD_A;
                end
                S_LD_A: begin
                    r_eng_in    <= '0;
                    r_strb      <= '0;
                    r_eng_ready <= 1'b1;
                    r_state     <= S_START;
                end
                S_START: begin
                    r_eng_ready <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion on the final count still beats the timeout.
                    if (eng_valid) begin
                        r_rsp_data    <= eng_out;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= N_REQ'(1) << r_owner;
                        r_state       <= S_RESP;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rsp_data    <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= N_REQ'(1) << r_owner;
                        r_eng_clr     <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= '0;
                    r_eng_clr   <= 1'b0;
                    r_ptr       <= r_owner;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant       = r_grant;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = (r_state != S_IDLE);
    assign eng_clr     = r_eng_clr;
    assign eng_in      = r_eng_in;
    assign eng_s1      = r_strb[0];
    assign eng_s2      = r_strb[1];
    assign eng_s3      = r_strb[2];
    assign eng_s4      = r_strb[3];
    assign eng_ready   = r_eng_ready;

endmodule
